// File: rtl/sprite_dma.sv
// Sprite DMA: bus master between the CPU data port and the memory controller.
// Copies a block of main-memory words into the sprite object table while the CPU is stalled.
module sprite_dma #(
    parameter logic [15:0] SPRITE_ADDR   = 16'h4000,
    parameter int          SPRITE_WORDS  = 512,
    parameter logic [15:0] DMA_SRC_ADDR  = 16'h4390,
    parameter logic [15:0] DMA_LEN_ADDR  = 16'h4391,
    parameter logic [15:0] DMA_CTRL_ADDR = 16'h4392
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_memaddr,
    input  logic        cpu_memwrite,
    input  logic [15:0] cpu_writedata,
    output logic [15:0] cpu_memdata,
    output logic        cpu_stall,
    input  logic        vbright,
    output logic [15:0] mc_memaddr,
    output logic        mc_memwrite,
    output logic [15:0] mc_writedata,
    input  logic [15:0] mc_memdata,
    output logic        dma_done
);

    localparam int OFF_W = $clog2(SPRITE_WORDS);
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(SPRITE_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        RD,
        CAP,
        WR,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        src_q, src_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [OFF_W-1:0]   dst_off_q, dst_off_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        latch_q, latch_d;
    logic               done_q, done_d;
    logic               rd_sel_q, rd_sel_d;
    logic [15:0]        rd_data_q, rd_data_d;

    logic               is_src, is_len, is_ctrl, is_reg;
    logic               busy;
    logic [CNT_W-1:0]   len_clamped;
    logic [CNT_W-1:0]   count_inc;
    logic [OFF_W-1:0]   dst_idx;
    logic [15:0]        src_addr;
    logic [15:0]        dst_addr;
    logic [15:0]        ctrl_rd;

    assign is_src  = (cpu_memaddr == DMA_SRC_ADDR);
    assign is_len  = (cpu_memaddr == DMA_LEN_ADDR);
    assign is_ctrl = (cpu_memaddr == DMA_CTRL_ADDR);
    assign is_reg  = is_src | is_len | is_ctrl;
    assign busy    = (state_q != IDLE);

    assign len_clamped = (len_q > MAX_LEN) ? MAX_LEN : len_q;
    assign count_inc   = count_q + 1'b1;
    // The offset adder is exactly OFF_W bits wide, so the destination wraps inside the table.
    assign dst_idx     = dst_off_q + count_q[OFF_W-1:0];
    assign src_addr    = src_q + 16'(count_q);
    assign dst_addr    = SPRITE_ADDR + 16'(dst_idx);

    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[OFF_W-1:0]     = dst_off_q;
        ctrl_rd[OFF_W]         = done_q;
        ctrl_rd[OFF_W+1]       = busy;
    end

    // Bus ownership: while cpu_stall is high the CPU must hold its request;
    // CPU writes are ignored and cpu_memdata carries no meaning.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        len_d        = len_q;
        dst_off_d    = dst_off_q;
        count_d      = count_q;
        latch_d      = latch_q;
        done_d       = done_q;
        mc_memaddr   = src_addr;
        mc_writedata = latch_q;
        mc_memwrite  = 1'b0;
        cpu_stall    = 1'b1;
        dma_done     = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_stall    = 1'b0;
                mc_memaddr   = cpu_memaddr;
                mc_writedata = cpu_writedata;
                mc_memwrite  = cpu_memwrite & ~is_reg;
                if (cpu_memwrite && is_src) begin
                    src_d = cpu_writedata;
                end
                if (cpu_memwrite && is_len) begin
                    len_d = cpu_writedata[CNT_W-1:0];
                end
                if (cpu_memwrite && is_ctrl) begin
                    done_d    = 1'b0;
                    dst_off_d = cpu_writedata[OFF_W+1:2];
                    if (cpu_writedata[0]) begin
                        count_d = '0;
                        len_d   = len_clamped;
                        if (len_clamped == '0) begin
                            state_d = FIN;
                        end else if (cpu_writedata[1]) begin
                            state_d = WAIT_VB;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            WAIT_VB: begin
                if (!vbright) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                // Address held a second cycle so the controller's registered read lands here.
                latch_d = mc_memdata;
                state_d = WR;
            end
            WR: begin
                mc_memaddr  = dst_addr;
                mc_memwrite = 1'b1;
                count_d     = count_inc;
                state_d     = (count_inc == len_q) ? FIN : RD;
            end
            FIN: begin
                dma_done = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_sel_d  = ~busy & is_reg;
        rd_data_d = ctrl_rd;
        if (is_src) begin
            rd_data_d = src_q;
        end else if (is_len) begin
            rd_data_d = 16'(len_q);
        end
    end

    assign cpu_memdata = rd_sel_q ? rd_data_q : mc_memdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            len_q     <= '0;
            dst_off_q <= '0;
            count_q   <= '0;
            latch_q   <= '0;
            done_q    <= 1'b0;
            rd_sel_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            len_q     <= len_d;
            dst_off_q <= dst_off_d;
            count_q   <= count_d;
            latch_q   <= latch_d;
            done_q    <= done_d;
            rd_sel_q  <= rd_sel_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: doc/sprite_dma.md
Name: sprite_dma

Overview:
- Bus master sits between the CPU data port and memory_controller's data port (memaddr/memwrite/writedata/memdata).
- Copies a block of words from main program memory into the sprite object table (0x4000–0x41FF) without CPU involvement.
- Stalls the CPU while a transfer runs.
- Programmed through three memory-mapped registers; CPU traffic to any other address passes through unchanged.

Parameters:
- SPRITE_ADDR, 16'h4000, base address of the sprite object table
- SPRITE_WORDS, 512, sprite table size in words (power of two)
- DMA_SRC_ADDR, 16'h4390, source address register
- DMA_LEN_ADDR, 16'h4391, word count register
- DMA_CTRL_ADDR, 16'h4392, control/status register

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_memaddr  in  16  CPU data address
- cpu_memwrite  in  1  CPU write strobe
- cpu_writedata  in  16  CPU write data
- cpu_memdata  out  16  read data returned to CPU
- cpu_stall  out  1  high while the DMA owns the bus
- vbright  in  1  vertical visible-region flag from the VGA timing block
- mc_memaddr  out  16  to memory_controller memaddr
- mc_memwrite  out  1  to memory_controller memwrite
- mc_writedata  out  16  to memory_controller writedata
- mc_memdata  in  16  from memory_controller memdata
- dma_done  out  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset (async, rst=1):
  - State IDLE; src, len, dst_off, count and the data latch all 0.
  - done flag 0, sync bit 0.
  - cpu_stall=0, dma_done=0; mc_* follow the CPU inputs.
- Registers, written only in IDLE:
  - SRC: 16-bit source address.
  - LEN: bits[9:0] hold the count. Values >SPRITE_WORDS clamp to SPRITE_WORDS at start.
  - CTRL write:
    - bit0 = start; bit1 = sync (wait for vblank).
    - bits[10:2] = destination offset dst_off within the sprite table.
    - Any CTRL write clears the done flag.
- Register writes in any state other than IDLE are dropped.
- CTRL read: {5'b0, busy, done, dst_off[8:0]}.
  - busy = state≠IDLE.
  - Field order (MSB→LSB): bits[15:11]=0, bit10=busy, bit9=done, bits[8:0]=dst_off.
- Register reads are registered: cpu_memdata presents the value one cycle after the address, matching memory_controller's misc-register latency.
- Pass-through (IDLE, address not a DMA register):
  - mc_memaddr=cpu_memaddr, mc_writedata=cpu_writedata, mc_memwrite=cpu_memwrite.
  - cpu_memdata=mc_memdata, combinational.
- DMA register addresses: mc_memwrite forced 0.
- FSM states: IDLE, WAIT_VB, RD, CAP, WR, FIN.
  - IDLE→WAIT_VB on a CTRL write with start=1 and sync=1; IDLE→RD on start=1, sync=0. count←0.
  - Start with LEN=0: IDLE→FIN directly; no memory access.
  - WAIT_VB: stay while vbright=1; →RD the first cycle vbright=0.
  - RD: mc_memaddr=src+count (16-bit wrap), mc_memwrite=0. →CAP.
  - CAP: same address held so memory_controller selects main-memory data; latch←mc_memdata at the clock edge. →WR.
  - WR: mc_memaddr=SPRITE_ADDR+((dst_off+count) mod SPRITE_WORDS), mc_writedata=latch, mc_memwrite=1. count←count+1. →FIN if count+1==len, else →RD.
  - FIN: dma_done=1 for exactly this cycle; done flag←1. →IDLE.
- Throughput: 3 cycles per word. Total = 3·len+1 cycles from the start edge to the return to IDLE, plus any WAIT_VB cycles.
- cpu_stall=1 in every state except IDLE. During a stall, CPU writes are not forwarded and cpu_memdata = mc_memdata (don't care).
- Destination wraps within the sprite table; it never writes outside 0x4000–0x41FF.
- Reset asserted mid-transfer aborts immediately. Sprite words already written stay written; done is not set.

Test Plan:
- Reset mid-WR → mc_memwrite=0 and cpu_stall=0 immediately (async); after release, CTRL reads 0x0000.
- Preload main[0x0100..0x0103]=A,B,C,D; write SRC=0x0100, LEN=4, CTRL=0x0001 → sprite[0x4000..0x4003]=A..D, cpu_stall high for 13 cycles, one dma_done pulse, CTRL reads 0x0200.
- dst_off=510, LEN=4, SRC=0x0200 → sprite 0x41FE, 0x41FF, 0x4000, 0x4001 written in that order; no write at 0x4200.
- CTRL=0x0003 with vbright=1 for 20 cycles → no mc_memwrite until vbright falls; the first RD follows the next cycle.
- LEN=0, CTRL start → stall for 1 cycle, dma_done pulses, sprite table unchanged.
- While busy, CPU writes SRC=0xFFFF → SRC unchanged after completion. Pass-through write of 0x0055 to 0x4381 (brightness) in IDLE reaches mc_* unmodified.
